// File: rtl/ps2_hotkeys.sv
// PS/2 hotkey decoder.
// Follows the receiver's byte stream and decodes the F0 (release) and E0
// (extended) prefixes. It tracks the level of the machine-control keys and
// turns them into registered reset, NMI, ROM-select, multiboot, tape-save
// and video-mode controls for the rest of the top level.
module ps2_hotkeys #(
    parameter logic ROM_INIT = 1'b0,
    parameter logic VGA_INIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        strb,
    input  logic [7:0]  code,
    input  logic        cfgLd,
    input  logic        cfgVga,
    output logic        make,
    output logic        extd,
    output logic [10:0] keys,
    output logic        rstn,
    output logic        nmi,
    output logic        rom,
    output logic        boot,
    output logic        save,
    output logic        vga
);

    // Bit positions inside the active-low key level vector
    localparam int K_F1   = 0;
    localparam int K_F2   = 1;
    localparam int K_F5   = 2;
    localparam int K_F10  = 3;
    localparam int K_F11  = 4;
    localparam int K_F12  = 5;
    localparam int K_BS   = 6;
    localparam int K_DEL  = 7;
    localparam int K_ALT  = 8;
    localparam int K_CTRL = 9;
    localparam int K_SLCK = 10;

    // Bit positions inside the edge-tracked subset {slck, F10, F2, F1}
    localparam int E_F1   = 0;
    localparam int E_F2   = 1;
    localparam int E_F10  = 2;
    localparam int E_SLCK = 3;

    logic        make_q,  make_d;
    logic        extd_q,  extd_d;
    logic [10:0] keys_q,  keys_d;
    logic [3:0]  dly_q,   dly_d;
    logic [3:0]  pulse_q, pulse_d;
    logic        rom_q,   rom_d;
    logic        save_q,  save_d;
    logic        vga_q,   vga_d;
    logic        rstn_q,  rstn_d;
    logic        nmi_q,   nmi_d;
    logic        boot_q,  boot_d;

    logic [3:0]  tracked;
    logic        byte_en;
    logic        ctrl_alt_del;

    assign byte_en      = ce & strb;
    assign tracked      = {keys_q[K_SLCK], keys_q[K_F10], keys_q[K_F2], keys_q[K_F1]};
    assign ctrl_alt_del = ~keys_q[K_CTRL] & ~keys_q[K_ALT] & ~keys_q[K_DEL];

    // Prefix and key-level decode. A non-prefix byte takes the pending make
    // state and then clears both prefixes. E0 is not used when matching.
    always_comb begin
        make_d = make_q;
        extd_d = extd_q;
        keys_d = keys_q;
        if (byte_en) begin
            case (code)
                8'hF0: make_d = 1'b1;
                8'hE0: extd_d = 1'b1;
                default: begin
                    make_d = 1'b0;
                    extd_d = 1'b0;
                    case (code)
                        8'h05:   keys_d[K_F1]   = make_q;
                        8'h06:   keys_d[K_F2]   = make_q;
                        8'h03:   keys_d[K_F5]   = make_q;
                        8'h09:   keys_d[K_F10]  = make_q;
                        8'h78:   keys_d[K_F11]  = make_q;
                        8'h07:   keys_d[K_F12]  = make_q;
                        8'h66:   keys_d[K_BS]   = make_q;
                        8'h71:   keys_d[K_DEL]  = make_q;
                        8'h11:   keys_d[K_ALT]  = make_q;
                        8'h14:   keys_d[K_CTRL] = make_q;
                        8'h7E:   keys_d[K_SLCK] = make_q;
                        default: keys_d = keys_q;
                    endcase
                end
            endcase
        end
    end

    // Press-pulse detection and the derived control outputs. The pulse
    // registers one ce period after the level falls. Auto-repeat leaves the
    // delayed copy low, so it cannot retrigger a pulse.
    always_comb begin
        dly_d   = dly_q;
        pulse_d = pulse_q;
        rom_d   = rom_q;
        save_d  = save_q;
        vga_d   = vga_q;
        rstn_d  = rstn_q;
        nmi_d   = nmi_q;
        boot_d  = boot_q;
        if (ce) begin
            dly_d   = tracked;
            pulse_d = ~tracked & dly_q;
            if (pulse_q[E_F1]) begin
                rom_d = 1'b0;
            end else if (pulse_q[E_F2]) begin
                rom_d = 1'b1;
            end
            if (pulse_q[E_F10]) begin
                save_d = ~save_q;
            end
            if (pulse_q[E_SLCK]) begin
                vga_d = ~vga_q;
            end
            rstn_d = ~(~keys_q[K_F12] | ctrl_alt_del | pulse_q[E_F1] | pulse_q[E_F2]);
            nmi_d  = keys_q[K_F5];
            boot_d = ~keys_q[K_F11] & (~keys_q[K_CTRL] | ~keys_q[K_ALT] | ~keys_q[K_BS]);
        end
        if (cfgLd) begin
            vga_d = cfgVga;
        end
    end

    // State registers; power-on reset only
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            make_q  <= 1'b0;
            extd_q  <= 1'b0;
            keys_q  <= 11'h7FF;
            dly_q   <= 4'hF;
            pulse_q <= 4'h0;
            rom_q   <= ROM_INIT;
            save_q  <= 1'b0;
            vga_q   <= VGA_INIT;
            rstn_q  <= 1'b1;
            nmi_q   <= 1'b1;
            boot_q  <= 1'b0;
        end else begin
            make_q  <= make_d;
            extd_q  <= extd_d;
            keys_q  <= keys_d;
            dly_q   <= dly_d;
            pulse_q <= pulse_d;
            rom_q   <= rom_d;
            save_q  <= save_d;
            vga_q   <= vga_d;
            rstn_q  <= rstn_d;
            nmi_q   <= nmi_d;
            boot_q  <= boot_d;
        end
    end

    assign make = make_q;
    assign extd = extd_q;
    assign keys = keys_q;
    assign rstn = rstn_q;
    assign nmi  = nmi_q;
    assign rom  = rom_q;
    assign boot = boot_q;
    assign save = save_q;
    assign vga  = vga_q;

endmodule

// File: tb/tb_ps2_hotkeys.sv
// Testbench for ps2_hotkeys.
// The stimulus sends scan bytes, one per ce period. It queues the expected
// output values, each tagged with the clock cycle at which the value must be
// visible. A monitor pops the due entries on every falling edge and compares
// them against the DUT.
module tb_ps2_hotkeys;

    localparam int S_MAKE = 0;
    localparam int S_EXTD = 1;
    localparam int S_KEYS = 2;
    localparam int S_RSTN = 3;
    localparam int S_NMI  = 4;
    localparam int S_ROM  = 5;
    localparam int S_BOOT = 6;
    localparam int S_SAVE = 7;
    localparam int S_VGA  = 8;

    logic        clock;
    logic        reset;
    logic        ce;
    logic        strb;
    logic [7:0]  code;
    logic        cfgLd;
    logic        cfgVga;
    logic        make;
    logic        extd;
    logic [10:0] keys;
    logic        rstn;
    logic        nmi;
    logic        rom;
    logic        boot;
    logic        save;
    logic        vga;

    typedef struct {
        int          due;
        int          sel;
        logic [10:0] exp;
        string       name;
    } expect_t;

    expect_t sb[$];
    int      cyc;
    int      nextCe;
    int      nChecks;
    int      nFails;

    ps2_hotkeys #(
        .ROM_INIT(1'b1),
        .VGA_INIT(1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .strb  (strb),
        .code  (code),
        .cfgLd (cfgLd),
        .cfgVga(cfgVga),
        .make  (make),
        .extd  (extd),
        .keys  (keys),
        .rstn  (rstn),
        .nmi   (nmi),
        .rom   (rom),
        .boot  (boot),
        .save  (save),
        .vga   (vga)
    );

    // Clock; cyc numbers the rising edges.
    initial begin
        clock = 1'b0;
        cyc   = 0;
        forever begin
            #5 clock = 1'b1;
            cyc = cyc + 1;
            #5 clock = 1'b0;
        end
    end

    function automatic logic [10:0] actual(input int sel);
        logic [10:0] v;
        v = 11'h0;
        case (sel)
            S_MAKE:  v = {10'h0, make};
            S_EXTD:  v = {10'h0, extd};
            S_KEYS:  v = keys;
            S_RSTN:  v = {10'h0, rstn};
            S_NMI:   v = {10'h0, nmi};
            S_ROM:   v = {10'h0, rom};
            S_BOOT:  v = {10'h0, boot};
            S_SAVE:  v = {10'h0, save};
            S_VGA:   v = {10'h0, vga};
            default: v = 11'h0;
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation that falls due on this cycle
    initial begin
        nChecks = 0;
        nFails  = 0;
        forever begin
            @(negedge clock);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    nChecks = nChecks + 1;
                    if (actual(sb[i].sel) !== sb[i].exp) begin
                        nFails = nFails + 1;
                        $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                                 sb[i].name, cyc, actual(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    nChecks = nChecks + 1;
                    nFails  = nFails + 1;
                    $display("[TB] FAIL %s never checked: due cycle %0d, now %0d",
                             sb[i].name, sb[i].due, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    // Anchor later expectations to the ce edge that the next ce period will use
    task automatic plan();
        nextCe = cyc + 1;
    endtask

    task automatic checkOutput(input string name, input int sel, input int offset,
                               input logic [10:0] value);
        expect_t e;
        e.due  = nextCe + offset;
        e.sel  = sel;
        e.exp  = value;
        e.name = name;
        sb.push_back(e);
    endtask

    // One ce period (4 clocks). ce is high only on the first clock. strb and
    // code are held for the whole period. cfgLd pulses on clock cfgAt (-1 = never).
    task automatic ceCycle(input logic s, input logic [7:0] c, input int cfgAt,
                           input logic cfgVal);
        for (int j = 0; j < 4; j++) begin
            ce     = (j == 0);
            strb   = s;
            code   = c;
            cfgLd  = (j == cfgAt);
            cfgVga = cfgVal;
            @(negedge clock);
        end
        ce    = 1'b0;
        strb  = 1'b0;
        cfgLd = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] c);
        ceCycle(1'b1, c, -1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) ceCycle(1'b0, 8'h00, -1, 1'b0);
    endtask

    // Directed stimulus
    initial begin
        reset  = 1'b0;
        ce     = 1'b0;
        strb   = 1'b0;
        code   = 8'h00;
        cfgLd  = 1'b0;
        cfgVga = 1'b0;
        nextCe = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset state
        plan();
        checkOutput("rst_keys", S_KEYS, 0, 11'h7FF);
        checkOutput("rst_make", S_MAKE, 0, 11'h0);
        checkOutput("rst_extd", S_EXTD, 0, 11'h0);
        checkOutput("rst_rstn", S_RSTN, 0, 11'h1);
        checkOutput("rst_nmi",  S_NMI,  0, 11'h1);
        checkOutput("rst_rom",  S_ROM,  0, 11'h1);
        checkOutput("rst_vga",  S_VGA,  0, 11'h0);
        checkOutput("rst_boot", S_BOOT, 0, 11'h0);
        checkOutput("rst_save", S_SAVE, 0, 11'h0);
        idle(2);

        // F1 press: rom -> 0, rstn low for exactly 4 clocks
        plan();
        checkOutput("f1_keys",    S_KEYS, 0,  11'h7FE);
        checkOutput("f1_rstn_pre", S_RSTN, 7,  11'h1);
        checkOutput("f1_rstn_lo0", S_RSTN, 8,  11'h0);
        checkOutput("f1_rstn_lo3", S_RSTN, 11, 11'h0);
        checkOutput("f1_rstn_end", S_RSTN, 12, 11'h1);
        checkOutput("f1_rom",     S_ROM,  8,  11'h0);
        applyStimulus(8'h05);
        plan();
        checkOutput("f0_make", S_MAKE, 0, 11'h1);
        applyStimulus(8'hF0);
        plan();
        checkOutput("f1_rel_keys", S_KEYS, 0, 11'h7FF);
        checkOutput("f1_rel_make", S_MAKE, 0, 11'h0);
        applyStimulus(8'h05);
        idle(3);

        // F2 press: rom -> 1, rstn pulses; a repeated make gives no second pulse
        plan();
        checkOutput("f2_keys",    S_KEYS, 0,  11'h7FD);
        checkOutput("f2_rom",     S_ROM,  8,  11'h1);
        checkOutput("f2_rstn_lo", S_RSTN, 8,  11'h0);
        checkOutput("f2_rstn_hi", S_RSTN, 12, 11'h1);
        applyStimulus(8'h06);
        plan();
        checkOutput("f2_rep_keys",  S_KEYS, 0,  11'h7FD);
        checkOutput("f2_rep_rstn8", S_RSTN, 8,  11'h1);
        checkOutput("f2_rep_rstn11", S_RSTN, 11, 11'h1);
        applyStimulus(8'h06);
        applyStimulus(8'hF0);
        plan();
        checkOutput("f2_rel_keys", S_KEYS, 0, 11'h7FF);
        applyStimulus(8'h06);
        idle(3);

        // Ctrl-Alt-Del holds rstn low until Delete is released
        plan();
        checkOutput("ctrl_keys", S_KEYS, 0, 11'h5FF);
        applyStimulus(8'h14);
        plan();
        checkOutput("alt_keys", S_KEYS, 0, 11'h4FF);
        checkOutput("ca_rstn",  S_RSTN, 4, 11'h1);
        applyStimulus(8'h11);
        plan();
        checkOutput("cad_keys", S_KEYS, 0, 11'h47F);
        checkOutput("cad_rstn", S_RSTN, 4, 11'h0);
        applyStimulus(8'h71);
        plan();
        checkOutput("cad_f0_rstn", S_RSTN, 4, 11'h0);
        applyStimulus(8'hF0);
        plan();
        checkOutput("del_rel_keys", S_KEYS, 0, 11'h4FF);
        checkOutput("del_rel_rstn", S_RSTN, 4, 11'h1);
        applyStimulus(8'h71);
        applyStimulus(8'hF0);
        plan();
        checkOutput("ctrl_rel_keys", S_KEYS, 0, 11'h6FF);
        applyStimulus(8'h14);
        applyStimulus(8'hF0);
        plan();
        checkOutput("alt_rel_keys", S_KEYS, 0, 11'h7FF);
        applyStimulus(8'h11);

        // Extended prefix: E0 14 is Ctrl; prefixes accumulate
        plan();
        checkOutput("e0_extd", S_EXTD, 0, 11'h1);
        checkOutput("e0_make", S_MAKE, 0, 11'h0);
        applyStimulus(8'hE0);
        plan();
        checkOutput("e0_ctrl_keys", S_KEYS, 0, 11'h5FF);
        checkOutput("e0_ctrl_extd", S_EXTD, 0, 11'h0);
        applyStimulus(8'h14);
        applyStimulus(8'hF0);
        plan();
        checkOutput("f0e0_make", S_MAKE, 0, 11'h1);
        checkOutput("f0e0_extd", S_EXTD, 0, 11'h1);
        applyStimulus(8'hE0);
        plan();
        checkOutput("e0_rel_keys", S_KEYS, 0, 11'h7FF);
        checkOutput("e0_rel_make", S_MAKE, 0, 11'h0);
        checkOutput("e0_rel_extd", S_EXTD, 0, 11'h0);
        applyStimulus(8'h14);
        idle(2);

        // Scroll Lock toggles vga twice, back to the initial value
        plan();
        checkOutput("slck_keys", S_KEYS, 0, 11'h3FF);
        checkOutput("slck_vga1", S_VGA,  8, 11'h1);
        applyStimulus(8'h7E);
        applyStimulus(8'hF0);
        applyStimulus(8'h7E);
        idle(1);
        plan();
        checkOutput("slck_vga0", S_VGA, 8, 11'h0);
        applyStimulus(8'h7E);
        applyStimulus(8'hF0);
        applyStimulus(8'h7E);
        idle(1);

        // cfgLd coinciding with the slck pulse wins over the toggle
        plan();
        checkOutput("cfg_vga_a", S_VGA, 8, 11'h1);
        applyStimulus(8'h7E);
        applyStimulus(8'hF0);
        ceCycle(1'b1, 8'h7E, 0, 1'b1);
        idle(1);
        plan();
        checkOutput("cfg_vga_b",    S_VGA, 8,  11'h1);
        checkOutput("cfg_vga_hold", S_VGA, 12, 11'h1);
        applyStimulus(8'h7E);
        applyStimulus(8'hF0);
        ceCycle(1'b1, 8'h7E, 0, 1'b1);
        idle(1);
        // cfgLd between ce edges
        plan();
        checkOutput("cfg_nce_pre", S_VGA, 1, 11'h1);
        checkOutput("cfg_nce",     S_VGA, 2, 11'h0);
        ceCycle(1'b0, 8'h00, 2, 1'b0);
        idle(1);

        // F10 toggles save; F5 drives nmi
        plan();
        checkOutput("f10_keys", S_KEYS, 0, 11'h7F7);
        checkOutput("f10_save", S_SAVE, 8, 11'h1);
        applyStimulus(8'h09);
        applyStimulus(8'hF0);
        applyStimulus(8'h09);
        plan();
        checkOutput("f5_keys", S_KEYS, 0, 11'h7FB);
        checkOutput("f5_nmi",  S_NMI,  4, 11'h0);
        applyStimulus(8'h03);
        applyStimulus(8'hF0);
        plan();
        checkOutput("f5_rel_nmi", S_NMI, 4, 11'h1);
        applyStimulus(8'h03);
        idle(2);

        // F11 with Backspace requests multiboot
        plan();
        checkOutput("f11_keys", S_KEYS, 0, 11'h7EF);
        checkOutput("f11_boot", S_BOOT, 4, 11'h0);
        applyStimulus(8'h78);
        plan();
        checkOutput("bs_keys", S_KEYS, 0, 11'h7AF);
        checkOutput("bs_boot", S_BOOT, 4, 11'h1);
        applyStimulus(8'h66);
        applyStimulus(8'hF0);
        plan();
        checkOutput("f11_rel_keys", S_KEYS, 0, 11'h7BF);
        checkOutput("f11_rel_boot", S_BOOT, 4, 11'h0);
        applyStimulus(8'h78);
        applyStimulus(8'hF0);
        plan();
        checkOutput("bs_rel_keys", S_KEYS, 0, 11'h7FF);
        applyStimulus(8'h66);
        idle(3);

        // Reset between F0 and 78 drops the pending release
        plan();
        checkOutput("pre_rst_make", S_MAKE, 0, 11'h1);
        applyStimulus(8'hF0);
        reset = 1'b0;
        plan();
        checkOutput("mid_rst_make", S_MAKE, 0, 11'h0);
        checkOutput("mid_rst_save", S_SAVE, 0, 11'h0);
        checkOutput("mid_rst_rom",  S_ROM,  0, 11'h1);
        checkOutput("mid_rst_keys", S_KEYS, 3, 11'h7FF);
        applyStimulus(8'h78);
        reset = 1'b1;
        idle(2);
        plan();
        checkOutput("post_rst_keys", S_KEYS, 0, 11'h7FF);
        checkOutput("post_rst_make", S_MAKE, 0, 11'h0);
        idle(2);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        while (sb.size() != 0) begin
            nChecks = nChecks + 1;
            nFails  = nFails + 1;
            $display("[TB] FAIL %s left pending: due cycle %0d, now %0d",
                     sb[0].name, sb[0].due, cyc);
            sb.delete(0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ps2_hotkeys.md
Name: ps2_hotkeys

Overview:
- Sits directly downstream of the PS/2 receiver and consumes its `strb`/`code` byte stream.
- Decodes the F0 (release) and E0 (extended) prefixes, then tracks the level of the machine-control keys: F1, F2, F5, F10, F11, F12, Backspace, Delete, Alt, Ctrl and Scroll Lock.
- Produces registered control outputs for the rest of the top level: system reset request, NMI, ROM select, multiboot request, tape-save monitor enable and VGA/RGB mode.
- Also exports `make`/`extd` so the keyboard matrix in main keeps receiving the prefix state.

Parameters:
- ROM_INIT, 1'b0: value of `rom` after reset.
- VGA_INIT, 1'b0: value of `vga` after reset.

Ports:
- clock  in  1  system clock (24 MHz)
- reset  in  1  asynchronous active-low reset (power-on only; never driven from `rstn`)
- ce  in  1  clock enable (6 MHz); all state advances only when ce=1
- strb  in  1  PS/2 byte valid, sampled with ce
- code  in  8  PS/2 scan byte
- cfgLd  in  1  one-cycle load of VGA mode from the flash config reader
- cfgVga  in  1  VGA mode value loaded by cfgLd
- make  out  1  1 = the current byte follows an F0 prefix (key release)
- extd  out  1  1 = the current byte follows an E0 prefix
- keys  out  11  active-low key levels {slck,ctrl,alt,del,bs,F12,F11,F10,F5,F2,F1}
- rstn  out  1  active-low machine reset request
- nmi  out  1  active-low NMI (F5 level)
- rom  out  1  ROM select
- boot  out  1  active-high multiboot request
- save  out  1  tape-out monitor enable
- vga  out  1  1 = scandoubled VGA output, 0 = 15 kHz RGB output

Behaviour:
- Reset (async, reset=0) values:
  - `make`=0, `extd`=0
  - `keys`=11'h7FF (all released); edge registers 1
  - `rom`=ROM_INIT, `vga`=VGA_INIT, `save`=0
  - hence `rstn`=1, `nmi`=1, `boot`=0
- Byte decode, evaluated on cycles with ce&strb:
  - code=F0: set make=1; nothing else changes.
  - code=E0: set extd=1; nothing else changes.
  - Any other code: update the matching key level to the current `make` value (0 = pressed, 1 = released), then clear make and extd in the same cycle.
  - Key codes:
    - F1=05, F2=06, F5=03, F10=09, F11=78, F12=07
    - bs=66, del=71, alt=11, ctrl=14, slck=7E
  - The E0 prefix is ignored for matching, so E0 11 is treated as Alt, E0 14 as Ctrl and E0 71 as Delete.
  - Unlisted codes only clear the prefixes.
- strb while ce=0 is ignored; the upstream receiver holds strb for a ce period.
- Edge detect:
  - Per edge-tracked key (F1, F2, F10, slck), a delayed copy updates on ce.
  - Press pulse p = !level & delayed.
  - p is registered and is high for exactly one ce period (4 clocks), starting the ce cycle after the level falls.
  - Auto-repeat makes (level already 0) produce no pulse.
- rom: on ce, if F1p then rom<=0, else if F2p then rom<=1. F1 wins if both pulses are present.
- save: toggles on F10p.
- vga:
  - cfgLd=1 loads cfgVga, regardless of ce.
  - Otherwise, on ce, slck press pulse toggles vga.
  - cfgLd has priority over a simultaneous toggle.
- rstn (registered):
  - 0 while F12 is pressed, or while ctrl, alt and del are all pressed.
  - Also 0 during an F1p/F2p pulse, so ROM switches restart the machine.
  - 1 otherwise.
- boot: registered; 1 while F11 is held together with any of ctrl, alt or bs.
- nmi: registered copy of the F5 level.
- Latency: output change is visible 1 ce period after the completing byte (levels), 2 ce periods for pulse-derived outputs.
- A prefix followed by another prefix accumulates both flags (F0 then E0 → make=1, extd=1).
- Reset asserted mid-sequence clears prefixes; a half-received F0 ... is lost by design.

Test Plan:
- After reset, no strobes → keys=7FF, rstn=1, nmi=1, rom=ROM_INIT, vga=VGA_INIT, boot=0, save=0.
- Bytes 05, F0 05 → rom goes 0; rstn low for exactly 4 clocks. Then 06, F0 06 → rom=1, rstn pulses low again. Repeated 06 make without a break → no second pulse.
- 14, 11, 71 → rstn stays 0 until F0 71 is received, then returns to 1. E0 14 alone → keys[ctrl]=0, extd=0 after the byte.
- 7E, F0 7E twice → vga toggles twice, returning to the initial value. cfgLd=1 with cfgVga=1 on the same cycle as the slck pulse → vga=1.
- 09, F0 09 → save=1. 03 → nmi=0 within 2 ce periods; F0 03 → nmi=1.
- 78 then 66 → boot=1. F0 78 → boot=0. Assert reset between F0 and 78 → make=0, F11 stays released.
